// File: rtl/qspi_flash_seq_pkg.sv
// Shared opcodes, error codes, state encodings and the page pattern generator
// for the QSPI flash bring-up sequencer.
package qspi_flash_seq_pkg;

    localparam logic [7:0] CMD_RDID   = 8'h9F;
    localparam logic [7:0] CMD_WREN   = 8'h06;
    localparam logic [7:0] CMD_WRVECR = 8'h61;
    localparam logic [7:0] CMD_SE     = 8'hD8;
    localparam logic [7:0] CMD_PP     = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_RDSR   = 8'h05;

    // Manufacturer byte of the N25Q family, the last ID byte seen by the controller
    localparam logic [7:0] JEDEC_ID   = 8'h20;
    localparam logic [7:0] VECR_QUAD  = 8'b010_01_111;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_ID     = 3'd1;
    localparam logic [2:0] ERR_CTRL   = 3'd2;
    localparam logic [2:0] ERR_POLL   = 3'd3;
    localparam logic [2:0] ERR_VERIFY = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RDID,
        S_CHK_ID,
        S_VECR,
        S_WREN_SE,
        S_SE,
        S_POLL,
        S_WREN_PP,
        S_PP,
        S_READ,
        S_DONE,
        S_FAIL
    } seq_state_t;

    typedef enum logic [1:0] {
        I_IDLE,
        I_TRIG,
        I_SKIP,
        I_WAIT
    } iss_state_t;

    function automatic logic [2047:0] page_pattern(input logic [7:0] seed,
                                                   input logic [7:0] page,
                                                   input int         nbytes);
        logic [2047:0] d;
        d = '0;
        for (int i = 0; i < 256; i++) begin
            if (i < nbytes) d[8*i +: 8] = seed + page + 8'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/qspi_cmd_issuer.sv
// Single-command handshake with qspi_mem_controller: one-cycle trigger, one
// cycle where busy is not yet valid, then wait for busy to fall.
module qspi_cmd_issuer
    import qspi_flash_seq_pkg::*;
(
    input  logic clk,
    input  logic RESET,
    input  logic go,
    input  logic busy,
    input  logic error,
    output logic trigger,
    output logic cmd_done,
    output logic cmd_err
);

    iss_state_t st, st_n;

    always_ff @(posedge clk) begin
        if (RESET) st <= I_IDLE;
        else       st <= st_n;
    end

    always_comb begin
        st_n     = st;
        trigger  = 1'b0;
        cmd_done = 1'b0;
        cmd_err  = 1'b0;
        case (st)
            I_IDLE: if (go) st_n = I_TRIG;
            I_TRIG: begin
                trigger = 1'b1;
                st_n    = I_SKIP;
            end
            // Controller raises busy only after it has seen the trigger
            I_SKIP: st_n = I_WAIT;
            I_WAIT: if (!busy) begin
                cmd_done = 1'b1;
                cmd_err  = error;
                st_n     = I_IDLE;
            end
            default: st_n = I_IDLE;
        endcase
    end

endmodule

// File: rtl/qspi_flash_seq.sv
// Flash bring-up/self-test sequencer: ID check, optional quad enable
// (QSPI_SEQ_QUAD_EN), sector erase, page program and read-back verify.
module qspi_flash_seq
    import qspi_flash_seq_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR   = 24'hA30000,
    parameter int          NUM_PAGES   = 4,
    parameter int          PAGE_BYTES  = 256,
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter int          STARTUP_DLY = 10000,
    parameter int          POLL_MAX    = 100000
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          start,
    output logic          done,
    output logic          pass,
    output logic [2:0]    err_code,
    output logic [7:0]    page_idx,
    output logic          trigger,
    output logic          quad,
    output logic [7:0]    cmd,
    output logic [23:0]   addr,
    output logic [2047:0] data_send,
    input  logic [7:0]    readout,
    input  logic          busy,
    input  logic          error
);

    localparam logic [31:0] DLY_END   = 32'(STARTUP_DLY);
    localparam logic [31:0] POLL_LAST = 32'(POLL_MAX - 1);
    localparam logic [7:0]  LAST_PAGE = 8'(NUM_PAGES - 1);

    seq_state_t    state, state_n;
    logic          issued, issued_n;
    logic          start_pend, start_pend_n;
    logic          from_pp, from_pp_n;
    logic [31:0]   dly_cnt;
    logic          dly_done;
    logic [31:0]   poll_cnt, poll_n;
    logic [7:0]    page_n;
    logic [2:0]    err_n;
    logic          done_n, pass_n, quad_n;
    logic [7:0]    cmd_n;
    logic [23:0]   addr_n;
    logic [2047:0] data_n;
    logic          go, is_cmd, cmd_done, cmd_err;
    logic [7:0]    op_cmd;
    logic [23:0]   op_addr;
    logic [2047:0] op_data;
    logic [23:0]   page_addr;
    logic [7:0]    exp_byte;

    assign dly_done  = (dly_cnt >= DLY_END);
    assign page_addr = BASE_ADDR + 24'(32'(page_idx) * 32'(PAGE_BYTES));
    assign exp_byte  = SEED + page_idx;

    qspi_cmd_issuer u_issuer (
        .clk      (clk),
        .RESET    (RESET),
        .go       (go),
        .busy     (busy),
        .error    (error),
        .trigger  (trigger),
        .cmd_done (cmd_done),
        .cmd_err  (cmd_err)
    );

    // Command presented by each command-issuing state
    always_comb begin
        is_cmd  = 1'b1;
        op_cmd  = 8'h00;
        op_addr = 24'h0;
        op_data = '0;
        case (state)
            S_RDID:    op_cmd = CMD_RDID;
            S_VECR: begin
                op_cmd       = CMD_WRVECR;
                op_data[7:0] = VECR_QUAD;
            end
            S_WREN_SE: op_cmd = CMD_WREN;
            S_SE: begin
                op_cmd  = CMD_SE;
                op_addr = BASE_ADDR;
            end
            S_POLL:    op_cmd = CMD_RDSR;
            S_WREN_PP: op_cmd = CMD_WREN;
            S_PP: begin
                op_cmd  = CMD_PP;
                op_addr = page_addr;
                op_data = page_pattern(SEED, page_idx, PAGE_BYTES);
            end
            S_READ: begin
                op_cmd  = CMD_READ;
                op_addr = page_addr;
            end
            default:   is_cmd = 1'b0;
        endcase
    end

    always_comb begin
        state_n      = state;
        issued_n     = issued;
        start_pend_n = start_pend;
        from_pp_n    = from_pp;
        poll_n       = poll_cnt;
        page_n       = page_idx;
        err_n        = err_code;
        done_n       = done;
        pass_n       = pass;
        quad_n       = quad;
        cmd_n        = cmd;
        addr_n       = addr;
        data_n       = data_send;
        go           = 1'b0;

        if (is_cmd && !issued) begin
            go       = 1'b1;
            issued_n = 1'b1;
            cmd_n    = op_cmd;
            addr_n   = op_addr;
            data_n   = op_data;
        end

        case (state)
            S_IDLE: begin
                if (start) start_pend_n = 1'b1;
                if ((start || start_pend) && dly_done) begin
                    start_pend_n = 1'b0;
                    page_n       = 8'd0;
                    state_n      = S_RDID;
                end
            end
            S_CHK_ID: begin
                if (readout != JEDEC_ID) begin
                    err_n   = ERR_ID;
                    done_n  = 1'b1;
                    state_n = S_FAIL;
                end else begin
`ifdef QSPI_SEQ_QUAD_EN
                    state_n = S_VECR;
`else
                    state_n = S_WREN_SE;
`endif
                end
            end
            S_DONE, S_FAIL: ;
            default: begin
                if (cmd_done) begin
                    issued_n = 1'b0;
                    if (cmd_err) begin
                        err_n   = ERR_CTRL;
                        done_n  = 1'b1;
                        state_n = S_FAIL;
                    end else begin
                        case (state)
                            S_RDID:    state_n = S_CHK_ID;
                            S_VECR: begin
                                quad_n  = 1'b1;
                                state_n = S_WREN_SE;
                            end
                            S_WREN_SE: state_n = S_SE;
                            S_SE: begin
                                from_pp_n = 1'b0;
                                poll_n    = 32'd0;
                                state_n   = S_POLL;
                            end
                            S_WREN_PP: state_n = S_PP;
                            S_PP: begin
                                from_pp_n = 1'b1;
                                poll_n    = 32'd0;
                                state_n   = S_POLL;
                            end
                            S_POLL: begin
                                if (!readout[0]) begin
                                    if (!from_pp) begin
                                        state_n = S_WREN_PP;
                                    end else if (page_idx == LAST_PAGE) begin
                                        page_n  = 8'd0;
                                        state_n = S_READ;
                                    end else begin
                                        page_n  = page_idx + 8'd1;
                                        state_n = S_WREN_PP;
                                    end
                                end else if (poll_cnt == POLL_LAST) begin
                                    err_n   = ERR_POLL;
                                    done_n  = 1'b1;
                                    state_n = S_FAIL;
                                end else begin
                                    // Staying in POLL with issued cleared re-issues RDSR
                                    poll_n = poll_cnt + 32'd1;
                                end
                            end
                            S_READ: begin
                                if (readout != exp_byte) begin
                                    err_n   = ERR_VERIFY;
                                    done_n  = 1'b1;
                                    state_n = S_FAIL;
                                end else if (page_idx == LAST_PAGE) begin
                                    done_n  = 1'b1;
                                    pass_n  = 1'b1;
                                    state_n = S_DONE;
                                end else begin
                                    page_n = page_idx + 8'd1;
                                end
                            end
                            default:   state_n = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= S_IDLE;
            issued     <= 1'b0;
            start_pend <= 1'b0;
            from_pp    <= 1'b0;
            dly_cnt    <= 32'd0;
            poll_cnt   <= 32'd0;
            page_idx   <= 8'd0;
            err_code   <= ERR_NONE;
            done       <= 1'b0;
            pass       <= 1'b0;
            quad       <= 1'b0;
            cmd        <= 8'h00;
            addr       <= 24'h0;
            data_send  <= '0;
        end else begin
            state      <= state_n;
            issued     <= issued_n;
            start_pend <= start_pend_n;
            from_pp    <= from_pp_n;
            if (!dly_done) dly_cnt <= dly_cnt + 32'd1;
            poll_cnt   <= poll_n;
            page_idx   <= page_n;
            err_code   <= err_n;
            done       <= done_n;
            pass       <= pass_n;
            quad       <= quad_n;
            cmd        <= cmd_n;
            addr       <= addr_n;
            data_send  <= data_n;
        end
    end

endmodule

// File: tb/tb_qspi_flash_seq.sv
// Bench for qspi_flash_seq with a behavioural controller+flash model; expects
// quad-mode results when QSPI_SEQ_QUAD_EN is defined for the build.
module tb_qspi_flash_seq;

    localparam logic [7:0] OP_RDID = 8'h9F, OP_WREN = 8'h06, OP_VECR = 8'h61;
    localparam logic [7:0] OP_SE = 8'hD8, OP_PP = 8'h02, OP_READ = 8'h03, OP_RDSR = 8'h05;

    logic          clk = 1'b0;
    logic          RESET = 1'b1;
    logic          start = 1'b0;
    logic          done, pass, trigger, quad;
    logic [2:0]    err_code;
    logic [7:0]    page_idx, cmd;
    logic [23:0]   addr;
    logic [2047:0] data_send;
    logic [7:0]    readout;
    logic          busy, error;

    always #5 clk = ~clk;

    qspi_flash_seq #(.STARTUP_DLY(20), .POLL_MAX(16)) dut (
        .clk(clk), .RESET(RESET), .start(start), .done(done), .pass(pass),
        .err_code(err_code), .page_idx(page_idx), .trigger(trigger), .quad(quad),
        .cmd(cmd), .addr(addr), .data_send(data_send), .readout(readout),
        .busy(busy), .error(error)
    );

    // Model configuration, written by the stimulus
    logic       m_wrong_id = 1'b0, m_wip_stuck = 1'b0, m_corrupt_en = 1'b0;
    logic [7:0] m_corrupt_pg = 8'd0, m_err_cmd = 8'd0;

    // Model state and observation counters (cleared by RESET like the controller)
    logic [7:0] mem [256];
    int         bcnt, wip_left, n_trig, n_rdsr, n_wren, n_se, n_pp, n_vecr;
    int         pp_addr_bad, payload_bad;
    logic [7:0] pend_rd, vecr_data;
    logic       pend_err, pp_quad;

    always @(posedge clk) begin
        if (RESET) begin
            busy <= 1'b0; error <= 1'b0; readout <= 8'h00; bcnt <= 0; wip_left <= 0;
            n_trig <= 0; n_rdsr <= 0; n_wren <= 0; n_se <= 0; n_pp <= 0; n_vecr <= 0;
            pp_addr_bad <= 0; payload_bad <= 0; pend_rd <= 8'h00; pend_err <= 1'b0;
            vecr_data <= 8'h00; pp_quad <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'hFF;
        end else if (trigger) begin
            busy     <= 1'b1;
            error    <= 1'b0;
            bcnt     <= 3;
            n_trig   <= n_trig + 1;
            pend_err <= (cmd == m_err_cmd);
            case (cmd)
                OP_RDID: pend_rd <= m_wrong_id ? 8'h5A : 8'h20;
                OP_RDSR: begin
                    n_rdsr  <= n_rdsr + 1;
                    pend_rd <= {7'd0, (m_wip_stuck || wip_left != 0)};
                    if (wip_left != 0) wip_left <= wip_left - 1;
                end
                OP_WREN: n_wren <= n_wren + 1;
                OP_SE: begin
                    n_se     <= n_se + 1;
                    wip_left <= 2;
                end
                OP_PP: begin
                    n_pp     <= n_pp + 1;
                    wip_left <= 2;
                    pp_quad  <= quad;
                    mem[addr[15:8]] <= (m_corrupt_en && addr[15:8] == m_corrupt_pg)
                                       ? ~data_send[7:0] : data_send[7:0];
                    if (addr != 24'hA30000 + 24'(n_pp * 256)) pp_addr_bad <= pp_addr_bad + 1;
                    if (data_send[15:8] != 8'hA5 + 8'(n_pp) + 8'd1 ||
                        data_send[2047:2040] != 8'hA5 + 8'(n_pp) + 8'd255)
                        payload_bad <= payload_bad + 1;
                end
                OP_READ: pend_rd <= mem[addr[15:8]];
                OP_VECR: begin
                    n_vecr    <= n_vecr + 1;
                    vecr_data <= data_send[7:0];
                end
                default: ;
            endcase
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) begin
                busy    <= 1'b0;
                readout <= pend_rd;
                error   <= pend_err;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        RESET = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (!done && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_finished"}, 32'(done), 32'd1);
    endtask

    typedef struct {
        logic       wrong_id;
        logic       wip_stuck;
        logic       corrupt_en;
        logic [7:0] corrupt_pg;
        logic [7:0] err_cmd;
        logic       exp_pass;
        logic [2:0] exp_err;
        logic [7:0] exp_page;
        int         exp_rdsr;
        int         exp_wren;
        int         exp_se;
        int         exp_pp;
    } vec_t;

    vec_t vecs[6];
    logic exp_q;

    initial begin
`ifdef QSPI_SEQ_QUAD_EN
        exp_q = 1'b1;
`else
        exp_q = 1'b0;
`endif
        //          id    stuck corr  pg     errcmd   pass err   page  rdsr wren se pp
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd0, 8'h00,   1'b1, 3'd0, 8'd3, 15,  5,   1, 4};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'd0, 8'h00,   1'b0, 3'd1, 8'd0, 0,   0,   0, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'd0, 8'h00,   1'b0, 3'd3, 8'd0, 16,  1,   1, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'd2, 8'h00,   1'b0, 3'd4, 8'd2, 15,  5,   1, 4};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd0, OP_SE,   1'b0, 3'd2, 8'd0, 0,   1,   1, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'd0, OP_PP,   1'b0, 3'd2, 8'd0, 3,   2,   1, 1};

        // Reset state
        do_reset();
        RESET = 1'b1;
        @(negedge clk);
        chk("rst_trigger", 32'(trigger), 32'd0);
        chk("rst_quad", 32'(quad), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        chk("rst_page", 32'(page_idx), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", 32'(|data_send), 32'd0);

        for (int i = 0; i < 6; i++) begin
            m_wrong_id   = vecs[i].wrong_id;
            m_wip_stuck  = vecs[i].wip_stuck;
            m_corrupt_en = vecs[i].corrupt_en;
            m_corrupt_pg = vecs[i].corrupt_pg;
            m_err_cmd    = vecs[i].err_cmd;
            do_reset();
            start = 1'b1;
            wait_done($sformatf("v%0d", i));
            repeat (5) @(negedge clk);
            chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
            chk($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].exp_pass));
            chk($sformatf("v%0d_err", i), 32'(err_code), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_page", i), 32'(page_idx), 32'(vecs[i].exp_page));
            chk($sformatf("v%0d_rdsr", i), 32'(n_rdsr), 32'(vecs[i].exp_rdsr));
            chk($sformatf("v%0d_wren", i), 32'(n_wren), 32'(vecs[i].exp_wren));
            chk($sformatf("v%0d_se", i), 32'(n_se), 32'(vecs[i].exp_se));
            chk($sformatf("v%0d_pp", i), 32'(n_pp), 32'(vecs[i].exp_pp));
            chk($sformatf("v%0d_trig_idle", i), 32'(trigger), 32'd0);
            start = 1'b0;
        end

        // Full pass: payload, addresses and quad setup
        m_wrong_id = 1'b0; m_wip_stuck = 1'b0; m_corrupt_en = 1'b0; m_err_cmd = 8'h00;
        do_reset();
        start = 1'b1;
        wait_done("full");
        chk("full_pass", 32'(pass), 32'd1);
        chk("full_pp_addr", 32'(pp_addr_bad), 32'd0);
        chk("full_payload", 32'(payload_bad), 32'd0);
        chk("full_pp_quad", 32'(pp_quad), 32'(exp_q));
        chk("full_vecr_cnt", 32'(n_vecr), exp_q ? 32'd1 : 32'd0);
        chk("full_vecr_data", 32'(vecr_data), exp_q ? 32'h4F : 32'h00);
        chk("full_mem_p0", 32'(mem[0]), 32'hA5);
        chk("full_mem_p1", 32'(mem[1]), 32'hA6);
        start = 1'b0;

        // Start pulsed before the startup delay expires is held pending
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("pend_no_early_cmd", 32'(n_trig), 32'd0);
        wait_done("pend");
        chk("pend_pass", 32'(pass), 32'd1);

        // Start while terminal is ignored; RESET mid-PP then restart
        do_reset();
        start = 1'b1;
        begin
            int c;
            c = 0;
            while (!(n_pp == 2 && busy) && c < 5000) begin
                @(negedge clk);
                c++;
            end
            chk("midpp_reached", 32'(n_pp == 2 && busy), 32'd1);
        end
        RESET = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midpp_trigger", 32'(trigger), 32'd0);
        chk("midpp_done", 32'(done), 32'd0);
        chk("midpp_page", 32'(page_idx), 32'd0);
        RESET = 1'b0;
        start = 1'b1;
        wait_done("restart");
        chk("restart_pass", 32'(pass), 32'd1);
        chk("restart_err", 32'(err_code), 32'd0);
        chk("restart_pp", 32'(n_pp), 32'd4);
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
